akumuluesi_prodhimeve: RTL and testbench

//  Sequential dot-product accumulator placed directly downstream of the 8x8 combinational

---
 rtl/akumuluesi_pkg.sv | 15 +
 rtl/akumuluesi_prodhimeve_mbledhesi.sv | 18 +
 rtl/akumuluesi_prodhimeve.sv | 119 +++++++++++
 tb/tb_akumuluesi_prodhimeve.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/akumuluesi_pkg.sv
// Shared types and default sizes for the product accumulator.
// Product width matches the 8x8 multiplier stage output.
package akumuluesi_pkg;

  localparam int PW_DEF      = 16;
  localparam int N_TERMS_DEF = 8;
  localparam int ACC_W_DEF   = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/akumuluesi_prodhimeve_mbledhesi.sv
// Unsigned W-bit saturating adder.
// On carry-out the sum clamps to all-ones and ovf is raised.
module mbledhesi_saturues #(
  parameter int W = 20
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         ovf
);

  logic [W:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign ovf  = full[W];
  assign sum  = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/akumuluesi_prodhimeve.sv
// Sequential dot-product accumulator: sums N_TERMS products per
// frame with saturation, result presented on a valid/ready port.
module akumuluesi_prodhimeve
  import akumuluesi_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int N_TERMS = N_TERMS_DEF,
  parameter int ACC_W   = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PW-1:0]    prodhimi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] shuma,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = $clog2(N_TERMS) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_TERMS - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [ACC_W-1:0] p_ext;
  logic [ACC_W-1:0] add_sum;
  logic             add_ovf;
  logic             beat;

  always_comb begin
    p_ext = '0;
    p_ext[PW-1:0] = prodhimi;
  end

  mbledhesi_saturues #(
    .W (ACC_W)
  ) u_add (
    .a   (acc_q),
    .b   (p_ext),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // in_ready depends on state only, never on in_valid
  assign in_ready = (state_q == ACC);
  assign beat     = in_valid & in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACC;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        ACC: begin
          if (beat) begin
            // once saturated the sum stays pinned at all-ones
            acc_d = (add_ovf | ovf_q) ? {ACC_W{1'b1}} : add_sum;
            ovf_d = add_ovf | ovf_q;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign shuma     = acc_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_akumuluesi_prodhimeve.sv
// Bench for the product accumulator: a 20-bit and an 18-bit
// instance share stimulus and are checked against a sum model.
module tb_akumuluesi_prodhimeve;

  localparam int N = 8;
  localparam longint MAX20 = (64'd1 << 20) - 1;
  localparam longint MAX18 = (64'd1 << 18) - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, clear, in_valid, out_ready;
  logic [15:0] prodhimi;

  logic        a_in_ready, a_out_valid, a_ovf, a_busy;
  logic [19:0] a_shuma;
  logic        b_in_ready, b_out_valid, b_ovf, b_busy;
  logic [17:0] b_shuma;

  int errors = 0;
  int checks = 0;
  longint sum_m = 0;

  always #5 clk = ~clk;

  akumuluesi_prodhimeve #(.PW(16), .N_TERMS(N), .ACC_W(20)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(a_in_ready), .prodhimi(prodhimi),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .shuma(a_shuma), .ovf(a_ovf), .busy(a_busy)
  );

  akumuluesi_prodhimeve #(.PW(16), .N_TERMS(N), .ACC_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .in_valid(in_valid), .in_ready(b_in_ready), .prodhimi(prodhimi),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .shuma(b_shuma), .ovf(b_ovf), .busy(b_busy)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint s, input longint mx);
    return (s > mx) ? mx : s;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // compare sums/overflow flags of both widths against the model
  task automatic chk_sum(input string tag);
    chk({tag, "_shuma20"}, longint'(a_shuma), sat(sum_m, MAX20));
    chk({tag, "_ovf20"},   longint'(a_ovf),   longint'(sum_m > MAX20));
    chk({tag, "_shuma18"}, longint'(b_shuma), sat(sum_m, MAX18));
    chk({tag, "_ovf18"},   longint'(b_ovf),   longint'(sum_m > MAX18));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  longint'(a_in_ready),  0);
    chk({tag, "_out_valid"}, longint'(a_out_valid), 0);
    chk({tag, "_busy"},      longint'(a_busy),      0);
    chk({tag, "_b_in_ready"}, longint'(b_in_ready), 0);
  endtask

  task automatic do_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    sum_m = 0;
    chk("start_in_ready", longint'(a_in_ready), 1);
    chk("start_busy",     longint'(a_busy),     1);
    chk_sum("start");
  endtask

  // one accepted beat, optionally preceded by random idle gaps
  task automatic feed(input logic [15:0] p, input bit gaps, input int idx);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        prodhimi = 16'($urandom);
        tick;
        chk("gap_hold_ready", longint'(a_in_ready), 1);
        chk_sum("gap_hold");
      end
    end
    in_valid = 1'b1;
    prodhimi = p;
    chk("beat_in_ready", longint'(a_in_ready), 1);
    tick;
    in_valid = 1'b0;
    sum_m += longint'(p);
    chk_sum("beat");
    chk("beat_out_valid", longint'(a_out_valid), longint'(idx == N - 1));
    chk("beat_b_out_valid", longint'(b_out_valid), longint'(idx == N - 1));
    chk("beat_in_ready_after", longint'(a_in_ready), longint'(idx != N - 1));
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk_idle("hs");
    chk_sum("hs_keep");
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    prodhimi = '0;
    #1;
    chk_idle("rst");
    chk("rst_shuma", longint'(a_shuma), 0);
    chk("rst_ovf",   longint'(a_ovf),   0);
    tick;
    rst_n = 1'b1;
    tick;
    chk_idle("post_rst");

    // reset in the middle of a frame
    do_start;
    for (int i = 0; i < 3; i++) feed(16'(100 * (i + 1)), 1'b0, i);
    #2 rst_n = 1'b0;
    #1;
    sum_m = 0;
    chk_idle("async_rst");
    chk_sum("async_rst");
    tick;
    rst_n = 1'b1;
    tick;
    chk_idle("after_rst");

    // 1..8 without gaps, then stall the output
    do_start;
    for (int i = 0; i < N; i++) feed(16'(i + 1), 1'b0, i);
    chk("sum36", longint'(a_shuma), 36);
    repeat (5) begin
      tick;
      chk("stall_valid", longint'(a_out_valid), 1);
      chk("stall_ready", longint'(a_in_ready),  0);
      chk("stall_shuma", longint'(a_shuma),     36);
    end
    handshake;

    // 255*255 with gaps: 20-bit fits, 18-bit saturates at beat 5
    do_start;
    for (int i = 0; i < N; i++) begin
      feed(16'd65025, 1'b1, i);
      chk("sat_ovf18_from5", longint'(b_ovf), longint'(i >= 4));
    end
    chk("sum520200", longint'(a_shuma), 520200);
    chk("sat18", longint'(b_shuma), 262143);
    handshake;

    // clear together with start after 4 beats
    do_start;
    for (int i = 0; i < 4; i++) feed(16'(7 + i), 1'b0, i);
    clear = 1'b1;
    start = 1'b1;
    tick;
    clear = 1'b0;
    start = 1'b0;
    sum_m = 0;
    chk_idle("clear");
    chk_sum("clear");
    repeat (4) begin
      in_valid = 1'b1;
      prodhimi = 16'd9;
      tick;
      chk("clear_no_valid", longint'(a_out_valid), 0);
      chk("clear_no_ready", longint'(a_in_ready),  0);
    end
    in_valid = 1'b0;

    // start during ACC and DONE must not restart the frame
    do_start;
    for (int i = 0; i < N; i++) begin
      start = (i == 3);
      feed(16'(11 * (i + 1)), 1'b0, i);
      start = 1'b0;
    end
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("done_start_valid", longint'(a_out_valid), 1);
    chk_sum("done_start");
    handshake;

    // back-to-back frames of 2s and 3s
    do_start;
    for (int i = 0; i < N; i++) feed(16'd2, 1'b0, i);
    chk("sum16", longint'(a_shuma), 16);
    handshake;
    do_start;
    for (int i = 0; i < N; i++) feed(16'd3, 1'b1, i);
    chk("sum24", longint'(a_shuma), 24);
    handshake;

    // random products and gaps
    repeat (3) begin
      do_start;
      for (int i = 0; i < N; i++) feed(16'($urandom), 1'b1, i);
      handshake;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
